// File: rtl/vfpu_job_sequencer_if.sv
// Control, stream-handshake and status signals exchanged between the VFPU job
// sequencer and its surroundings (control slave, source/sink streams).
interface vfpu_job_sequencer_if #(
    parameter int NB_OPERANDS = 2,
    parameter int CNT_WIDTH   = 16,
    parameter int WDOG_WIDTH  = 16
) ();
    logic                   clear_i;
    logic                   start_i;
    logic [CNT_WIDTH-1:0]   len_i;
    logic [WDOG_WIDTH-1:0]  wdog_lim_i;
    logic [NB_OPERANDS-1:0] src_ready_i;
    logic                   sink_ready_i;
    logic [NB_OPERANDS-1:0] src_req_start_o;
    logic                   sink_req_start_o;
    logic                   res_valid_i;
    logic                   res_ready_i;
    logic                   sink_done_i;
    logic                   busy_o;
    logic                   done_o;
    logic                   err_o;
    logic [CNT_WIDTH-1:0]   elem_cnt_o;

    modport slave (
        input  clear_i, start_i, len_i, wdog_lim_i, src_ready_i, sink_ready_i,
        input  res_valid_i, res_ready_i, sink_done_i,
        output src_req_start_o, sink_req_start_o, busy_o, done_o, err_o, elem_cnt_o
    );

    modport master (
        output clear_i, start_i, len_i, wdog_lim_i, src_ready_i, sink_ready_i,
        output res_valid_i, res_ready_i, sink_done_i,
        input  src_req_start_o, sink_req_start_o, busy_o, done_o, err_o, elem_cnt_o
    );
endinterface

// File: rtl/vfpu_job_sequencer.sv
// Sequences one VFPU job: waits for all streams, launches them together, counts
// result handshakes, waits for the sink to finish, and guards progress with a watchdog.
module vfpu_job_sequencer #(
    parameter int NB_OPERANDS = 2,
    parameter int CNT_WIDTH   = 16,
    parameter int WDOG_WIDTH  = 16
) (
    input logic                 clk_i,
    input logic                 rst_ni,
    vfpu_job_sequencer_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WAIT_RDY = 3'd1,
        LAUNCH   = 3'd2,
        RUN      = 3'd3,
        DRAIN    = 3'd4,
        DONE     = 3'd5,
        ERR      = 3'd6
    } state_e;

    state_e                state_r;
    state_e                state_s;
    logic [CNT_WIDTH-1:0]  len_r;
    logic [CNT_WIDTH-1:0]  len_s;
    logic [CNT_WIDTH-1:0]  cnt_r;
    logic [CNT_WIDTH-1:0]  cnt_s;
    logic [CNT_WIDTH-1:0]  cnt_inc_s;
    logic [WDOG_WIDTH-1:0] wdog_r;
    logic [WDOG_WIDTH-1:0] wdog_s;
    logic [WDOG_WIDTH-1:0] wdog_inc_s;
    logic                  wdog_hit_s;
    logic                  all_rdy_s;
    logic                  hs_s;
    logic                  done_r;

    // A handshake only counts in RUN and never past the latched length.
    assign hs_s       = (state_r == RUN) && bus.res_valid_i && bus.res_ready_i && (cnt_r < len_r);
    assign cnt_inc_s  = cnt_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    assign wdog_inc_s = wdog_r + {{(WDOG_WIDTH-1){1'b0}}, 1'b1};
    assign wdog_hit_s = (bus.wdog_lim_i != {WDOG_WIDTH{1'b0}}) && (wdog_inc_s == bus.wdog_lim_i);
    assign all_rdy_s  = (&bus.src_ready_i) && bus.sink_ready_i;

    // Next-state, length latch, element counter and watchdog count.
    always_comb begin
        state_s = state_r;
        len_s   = len_r;
        cnt_s   = cnt_r;
        wdog_s  = {WDOG_WIDTH{1'b0}};
        case (state_r)
            IDLE: begin
                if (bus.start_i) begin
                    len_s = bus.len_i;
                    cnt_s = {CNT_WIDTH{1'b0}};
                    if (bus.len_i != {CNT_WIDTH{1'b0}}) begin
                        state_s = WAIT_RDY;
                    end else begin
                        state_s = DONE;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            WAIT_RDY: begin
                if (all_rdy_s) begin
                    state_s = LAUNCH;
                end else if (wdog_hit_s) begin
                    state_s = ERR;
                end else begin
                    wdog_s = wdog_inc_s;
                end
            end
            LAUNCH: begin
                state_s = RUN;
            end
            RUN: begin
                if (hs_s) begin
                    cnt_s = cnt_inc_s;
                    if (cnt_inc_s == len_r) begin
                        state_s = bus.sink_done_i ? DONE : DRAIN;
                    end else if (bus.sink_done_i) begin
                        state_s = ERR;
                    end else begin
                        state_s = RUN;
                    end
                end else if (bus.sink_done_i || wdog_hit_s) begin
                    state_s = ERR;
                end else begin
                    wdog_s = wdog_inc_s;
                end
            end
            DRAIN: begin
                if (bus.sink_done_i) begin
                    state_s = DONE;
                end else if (wdog_hit_s) begin
                    state_s = ERR;
                end else begin
                    wdog_s = wdog_inc_s;
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            ERR: begin
                state_s = ERR;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State register; done_o is a registered echo of the DONE state.
    always_ff @(posedge clk_i) begin
        if (!rst_ni || bus.clear_i) begin
            state_r <= IDLE;
            len_r   <= {CNT_WIDTH{1'b0}};
            cnt_r   <= {CNT_WIDTH{1'b0}};
            wdog_r  <= {WDOG_WIDTH{1'b0}};
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            len_r   <= len_s;
            cnt_r   <= cnt_s;
            wdog_r  <= wdog_s;
            done_r  <= (state_r == DONE);
        end
    end

    assign bus.src_req_start_o  = {NB_OPERANDS{state_r == LAUNCH}};
    assign bus.sink_req_start_o = (state_r == LAUNCH);
    assign bus.busy_o           = (state_r != IDLE);
    assign bus.done_o           = done_r;
    assign bus.err_o            = (state_r == ERR);
    assign bus.elem_cnt_o       = cnt_r;
endmodule

// File: tb/tb_vfpu_job_sequencer.sv
// Randomized self-checking bench for vfpu_job_sequencer; expectations come from a
// cycle-timeline model of the job protocol kept in the bench.
module tb_vfpu_job_sequencer;
    localparam int NB = 2;
    localparam int CW = 16;
    localparam int WW = 16;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    vfpu_job_sequencer_if #(.NB_OPERANDS(NB), .CNT_WIDTH(CW), .WDOG_WIDTH(WW)) bus ();

    vfpu_job_sequencer #(.NB_OPERANDS(NB), .CNT_WIDTH(CW), .WDOG_WIDTH(WW)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.clear_i = 1'b0; bus.start_i = 1'b0; bus.len_i = 16'd0; bus.wdog_lim_i = 16'd0;
        bus.src_ready_i = {NB{1'b1}}; bus.sink_ready_i = 1'b1;
        bus.res_valid_i = 1'b0; bus.res_ready_i = 1'b0; bus.sink_done_i = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        step(); step();
        rst_n = 1'b1;
        n_cmp++; if (bus.busy_o !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", bus.busy_o); end
        n_cmp++; if (bus.done_o !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", bus.done_o); end
        n_cmp++; if (bus.err_o !== 1'b0) begin n_err++; $display("FAIL reset_err: got %b want 0", bus.err_o); end
        n_cmp++; if ({bus.src_req_start_o, bus.sink_req_start_o} !== 3'b000) begin n_err++; $display("FAIL reset_req: got %b want 000", {bus.src_req_start_o, bus.sink_req_start_o}); end
        n_cmp++; if (bus.elem_cnt_o !== 16'd0) begin n_err++; $display("FAIL reset_cnt: got %0d want 0", bus.elem_cnt_o); end
    endtask

    task automatic test_zero_len();
        bus.start_i = 1'b1; bus.len_i = 16'd0;
        step();
        bus.start_i = 1'b0;
        n_cmp++; if ({bus.src_req_start_o, bus.sink_req_start_o, bus.done_o} !== 4'b0000) begin n_err++; $display("FAIL zero_len_c1: got req/done %b want 0000", {bus.src_req_start_o, bus.sink_req_start_o, bus.done_o}); end
        step();
        n_cmp++; if (bus.done_o !== 1'b1) begin n_err++; $display("FAIL zero_len_done: got %b want 1", bus.done_o); end
        n_cmp++; if ({bus.src_req_start_o, bus.sink_req_start_o, bus.busy_o} !== 4'b0000) begin n_err++; $display("FAIL zero_len_c2: got req/busy %b want 0000", {bus.src_req_start_o, bus.sink_req_start_o, bus.busy_o}); end
        step();
        n_cmp++; if (bus.done_o !== 1'b0) begin n_err++; $display("FAIL zero_len_pulse: got %b want 0", bus.done_o); end
    endtask

    // One complete job: ready withheld rdy_dly cycles (src_ready[1] low), random result traffic.
    task automatic test_job(input int len, input int rdy_dly);
        int  exp_cnt;
        int  cyc;
        int  gap;
        bit  v;
        bit  r;
        bit  sd;
        logic [NB-1:0] not_rdy;
        not_rdy = {NB{1'b1}};
        not_rdy[1] = 1'b0;
        bus.wdog_lim_i = 16'd0;
        bus.src_ready_i = not_rdy; bus.sink_ready_i = 1'b1;
        bus.start_i = 1'b1; bus.len_i = 16'(len);
        step();
        bus.start_i = 1'b0; bus.len_i = 16'(($urandom_range(0, 7)));
        n_cmp++; if (bus.busy_o !== 1'b1) begin n_err++; $display("FAIL job_busy_start: got %b want 1", bus.busy_o); end
        for (int i = 0; i <= rdy_dly; i++) begin
            if (i == rdy_dly) bus.src_ready_i = {NB{1'b1}};
            n_cmp++; if ({bus.src_req_start_o, bus.sink_req_start_o} !== 3'b000) begin n_err++; $display("FAIL job_wait_req: cycle %0d got %b want 000", i, {bus.src_req_start_o, bus.sink_req_start_o}); end
            step();
        end
        n_cmp++; if ({bus.src_req_start_o, bus.sink_req_start_o} !== 3'b111) begin n_err++; $display("FAIL job_launch: got %b want 111", {bus.src_req_start_o, bus.sink_req_start_o}); end
        bus.res_valid_i = 1'b1; bus.res_ready_i = 1'b1;
        step();
        exp_cnt = 0; cyc = 0; sd = 1'b0;
        while (exp_cnt < len && cyc < 200) begin
            n_cmp++; if (bus.elem_cnt_o !== 16'(exp_cnt)) begin n_err++; $display("FAIL job_cnt: got %0d want %0d", bus.elem_cnt_o, exp_cnt); end
            n_cmp++; if ({bus.src_req_start_o, bus.sink_req_start_o, bus.done_o, bus.busy_o} !== 5'b00001) begin n_err++; $display("FAIL job_run_flags: got %b want 00001", {bus.src_req_start_o, bus.sink_req_start_o, bus.done_o, bus.busy_o}); end
            v = ($urandom_range(0, 3) != 0);
            r = ($urandom_range(0, 3) != 0);
            bus.res_valid_i = v; bus.res_ready_i = r;
            if (v && r) exp_cnt++;
            if (v && r && exp_cnt == len) sd = 1'($urandom_range(0, 1));
            bus.sink_done_i = sd;
            step(); cyc++;
        end
        n_cmp++; if (cyc >= 200) begin n_err++; $display("FAIL job_timeout: got %0d cycles want < 200", cyc); end
        if (!sd) begin
            gap = $urandom_range(0, 3);
            for (int i = 0; i < gap; i++) begin
                bus.res_valid_i = 1'b1; bus.res_ready_i = 1'b1;
                n_cmp++; if ({bus.busy_o, bus.done_o} !== 2'b10) begin n_err++; $display("FAIL job_drain_flags: got %b want 10", {bus.busy_o, bus.done_o}); end
                step();
                n_cmp++; if (bus.elem_cnt_o !== 16'(len)) begin n_err++; $display("FAIL job_saturate: got %0d want %0d", bus.elem_cnt_o, len); end
            end
            bus.sink_done_i = 1'b1;
            step();
        end
        bus.sink_done_i = 1'b0; bus.res_valid_i = 1'b0; bus.res_ready_i = 1'b0;
        n_cmp++; if ({bus.busy_o, bus.done_o, bus.err_o} !== 3'b100) begin n_err++; $display("FAIL job_done_state: got busy/done/err %b want 100", {bus.busy_o, bus.done_o, bus.err_o}); end
        n_cmp++; if (bus.elem_cnt_o !== 16'(len)) begin n_err++; $display("FAIL job_final_cnt: got %0d want %0d", bus.elem_cnt_o, len); end
        step();
        n_cmp++; if ({bus.busy_o, bus.done_o} !== 2'b01) begin n_err++; $display("FAIL job_done_pulse: got busy/done %b want 01", {bus.busy_o, bus.done_o}); end
        step();
        n_cmp++; if (bus.done_o !== 1'b0) begin n_err++; $display("FAIL job_done_single: got %b want 0", bus.done_o); end
    endtask

    // Starts a job with all streams ready, reaches RUN and performs n_hs handshakes.
    task automatic start_and_shake(input int len, input int lim, input int n_hs);
        bus.wdog_lim_i = 16'(lim); bus.src_ready_i = {NB{1'b1}}; bus.sink_ready_i = 1'b1;
        bus.start_i = 1'b1; bus.len_i = 16'(len);
        step();
        bus.start_i = 1'b0;
        step(); step();
        bus.res_valid_i = 1'b1; bus.res_ready_i = 1'b1;
        for (int i = 0; i < n_hs; i++) step();
        bus.res_valid_i = 1'b0; bus.res_ready_i = 1'b0;
    endtask

    task automatic test_clear_from_err(input string tag);
        bus.start_i = 1'b1; bus.len_i = 16'd3;
        step();
        bus.start_i = 1'b0;
        n_cmp++; if ({bus.err_o, bus.busy_o, bus.src_req_start_o, bus.sink_req_start_o, bus.done_o} !== 6'b110000) begin n_err++; $display("FAIL %s_start_ignored: got %b want 110000", tag, {bus.err_o, bus.busy_o, bus.src_req_start_o, bus.sink_req_start_o, bus.done_o}); end
        bus.clear_i = 1'b1;
        step();
        bus.clear_i = 1'b0;
        n_cmp++; if ({bus.err_o, bus.busy_o, bus.done_o} !== 3'b000) begin n_err++; $display("FAIL %s_clear: got err/busy/done %b want 000", tag, {bus.err_o, bus.busy_o, bus.done_o}); end
    endtask

    task automatic test_watchdog_run();
        start_and_shake(4, 8, 2);
        for (int k = 1; k <= 8; k++) begin
            n_cmp++; if ({bus.err_o, bus.done_o} !== 2'b00) begin n_err++; $display("FAIL wdog_run_early: stall %0d got err/done %b want 00", k, {bus.err_o, bus.done_o}); end
            step();
        end
        n_cmp++; if ({bus.err_o, bus.busy_o, bus.done_o} !== 3'b110) begin n_err++; $display("FAIL wdog_run_err: got err/busy/done %b want 110", {bus.err_o, bus.busy_o, bus.done_o}); end
        n_cmp++; if (bus.elem_cnt_o !== 16'd2) begin n_err++; $display("FAIL wdog_run_cnt: got %0d want 2", bus.elem_cnt_o); end
        test_clear_from_err("wdog_run");
    endtask

    task automatic test_watchdog_wait();
        int lim;
        lim = $urandom_range(3, 6);
        bus.wdog_lim_i = 16'(lim); bus.sink_ready_i = 1'b0;
        bus.start_i = 1'b1; bus.len_i = 16'd2;
        step();
        bus.start_i = 1'b0;
        for (int k = 1; k <= lim; k++) begin
            n_cmp++; if (bus.err_o !== 1'b0) begin n_err++; $display("FAIL wdog_wait_early: cycle %0d lim %0d got %b want 0", k, lim, bus.err_o); end
            step();
        end
        n_cmp++; if (bus.err_o !== 1'b1) begin n_err++; $display("FAIL wdog_wait_err: lim %0d got %b want 1", lim, bus.err_o); end
        bus.sink_ready_i = 1'b1;
        test_clear_from_err("wdog_wait");
    endtask

    task automatic test_early_done();
        start_and_shake(4, 0, 2);
        bus.sink_done_i = 1'b1;
        step();
        bus.sink_done_i = 1'b0;
        n_cmp++; if ({bus.err_o, bus.busy_o, bus.done_o} !== 3'b110) begin n_err++; $display("FAIL early_done_err: got err/busy/done %b want 110", {bus.err_o, bus.busy_o, bus.done_o}); end
        n_cmp++; if (bus.elem_cnt_o !== 16'd2) begin n_err++; $display("FAIL early_done_cnt: got %0d want 2", bus.elem_cnt_o); end
        step(); step();
        n_cmp++; if (bus.err_o !== 1'b1) begin n_err++; $display("FAIL early_done_sticky: got %b want 1", bus.err_o); end
        test_clear_from_err("early_done");
    endtask

    task automatic test_reset_mid_run();
        start_and_shake(4, 0, 2);
        n_cmp++; if (bus.elem_cnt_o !== 16'd2) begin n_err++; $display("FAIL rst_mid_cnt_before: got %0d want 2", bus.elem_cnt_o); end
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        n_cmp++; if ({bus.busy_o, bus.done_o, bus.err_o, bus.src_req_start_o, bus.sink_req_start_o} !== 6'b000000) begin n_err++; $display("FAIL rst_mid_flags: got %b want 000000", {bus.busy_o, bus.done_o, bus.err_o, bus.src_req_start_o, bus.sink_req_start_o}); end
        n_cmp++; if (bus.elem_cnt_o !== 16'd0) begin n_err++; $display("FAIL rst_mid_cnt: got %0d want 0", bus.elem_cnt_o); end
        step();
        n_cmp++; if (bus.done_o !== 1'b0) begin n_err++; $display("FAIL rst_mid_no_done: got %b want 0", bus.done_o); end
        test_job(4, 0);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_zero_len();
        test_job(4, 0);
        for (int j = 0; j < 8; j++) test_job($urandom_range(1, 8), $urandom_range(0, 4));
        test_job(4, 10);
        test_watchdog_run();
        test_watchdog_wait();
        test_early_done();
        test_reset_mid_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got time %0t want finish before 200000", $time);
        $fatal(1, "timeout");
    end
endmodule
